ralu_multi: RTL and testbench

Parametrised successor of the 4-bit register/ALU datapath. It has a W-bit datapath, an N-entry general-register file with two read ports and one write port, operand registers A and B, and an accumulator output register. It adds a sequenced multi-bit shift of register B with a busy handshake, plus latched zero and carry flags. It sits under the control unit, which drives all select and enable lines each cycle.

---
 rtl/ralu_multi_if.sv | 24 ++
 rtl/ralu_multi.sv | 188 ++++++++++++++++++
 tb/tb_ralu_multi.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ralu_multi_if.sv
// Multi-shift handshake between the control unit and ralu_multi.
// The control unit drives start/dir/shcnt and watches busy.
interface ralu_multi_if #(
   parameter int CW = 3
) ();
   logic          start;
   logic          dir;
   logic [CW-1:0] shcnt;
   logic          busy;

   modport master (
      output start,
      output dir,
      output shcnt,
      input  busy
   );

   modport slave (
      input  start,
      input  dir,
      input  shcnt,
      output busy
   );
endinterface

// File: rtl/ralu_multi.sv
// W-bit register/ALU datapath with an N-entry register file,
// accumulator, flags and a sequenced multi-bit shift of register B.
module ralu_multi #(
   parameter int W  = 4,
   parameter int N  = 8,
   parameter int AW = 3,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  DataIn,
   output logic [W-1:0]  Rout,
   input  logic [2:0]    op,
   input  logic          Pin,
   output logic          Pout,
   input  logic          selA,
   input  logic          ldA,
   input  logic [1:0]    bmode,
   input  logic          acen,
   input  logic          ISL,
   input  logic          ISR,
   output logic          OSL,
   output logic          OSR,
   input  logic [AW-1:0] adr_a,
   input  logic [AW-1:0] adr_b,
   input  logic [AW-1:0] adr_w,
   input  logic          wr,
   ralu_multi_if.slave   sh,
   output logic          Z,
   output logic          C
);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   localparam logic [AW:0] NL = (AW+1)'(N);

   logic [W-1:0]  r_rf [N];
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_rout;
   logic          r_osl;
   logic          r_osr;
   logic          r_z;
   logic          r_c;
   logic          r_dir;
   logic [CW-1:0] r_cnt;
   state_t        r_state;
   state_t        w_next;

   logic [W-1:0]  w_rda;
   logic [W-1:0]  w_rdb;
   logic [W-1:0]  w_bop;
   logic [W:0]    w_sum;
   logic [W-1:0]  w_r;
   logic          w_pout;
   logic          w_go;
   logic          w_busy;

   // Out-of-range reads return zero.
   always_comb begin
      w_rda = '0;
      w_rdb = '0;
      if ({1'b0, adr_a} < NL)
         w_rda = r_rf[adr_a];
      if ({1'b0, adr_b} < NL)
         w_rdb = r_rf[adr_b];
   end

   assign w_bop = (op == 3'b001) ? ~r_b : r_b;
   assign w_sum = {1'b0, r_a} + {1'b0, w_bop}
                + {{W{1'b0}}, Pin};

   always_comb begin
      w_r    = '0;
      w_pout = 1'b0;
      case (op)
         3'b000, 3'b001: begin
            w_r    = w_sum[W-1:0];
            w_pout = w_sum[W];
         end
         3'b010:  w_r = r_a & r_b;
         3'b011:  w_r = r_a | r_b;
         3'b100:  w_r = r_a ^ r_b;
         3'b101:  w_r = r_a;
         3'b110:  w_r = r_b;
         default: w_r = ~r_a;
      endcase
   end

   assign w_go = (r_state == S_IDLE) && sh.start
              && (sh.shcnt != '0);

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:
            if (w_go)
               w_next = S_SHIFT;
         default:
            if (r_cnt == CW'(1))
               w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state == S_SHIFT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_dir <= 1'b0;
      end else if (w_go) begin
         r_cnt <= sh.shcnt;
         r_dir <= sh.dir;
      end else if (w_busy) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++)
            r_rf[i] <= '0;
      end else if (wr && ({1'b0, adr_w} < NL)) begin
         r_rf[adr_w] <= w_r;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_a <= '0;
      else if (ldA)
         r_a <= selA ? DataIn : w_rda;
   end

   // The start edge itself leaves B untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_b   <= '0;
         r_osl <= 1'b0;
         r_osr <= 1'b0;
      end else if (w_busy) begin
         if (r_dir)
            {r_b, r_osr} <= {ISR, r_b};
         else
            {r_osl, r_b} <= {r_b, ISL};
      end else if (!w_go) begin
         case (bmode)
            2'b01:   {r_osl, r_b} <= {r_b, ISL};
            2'b10:   {r_b, r_osr} <= {ISR, r_b};
            2'b11:   r_b <= w_rdb;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rout <= '0;
         r_z    <= 1'b0;
         r_c    <= 1'b0;
      end else if (acen) begin
         r_rout <= w_r;
         r_z    <= (w_r == '0);
         r_c    <= w_pout;
      end
   end

   assign Rout    = r_rout;
   assign Pout    = w_pout;
   assign OSL     = r_osl;
   assign OSR     = r_osr;
   assign Z       = r_z;
   assign C       = r_c;
   assign sh.busy = w_busy;

endmodule

// File: tb/tb_ralu_multi.sv
// Directed self-checking bench for ralu_multi.
// Inputs change 1ns after the rising edge, outputs are sampled there.
module tb_ralu_multi;

   logic       clk;
   logic       reset;
   logic [3:0] DataIn;
   logic [3:0] Rout;
   logic [2:0] op;
   logic       Pin;
   logic       Pout;
   logic       selA;
   logic       ldA;
   logic [1:0] bmode;
   logic       acen;
   logic       ISL;
   logic       ISR;
   logic       OSL;
   logic       OSR;
   logic [2:0] adr_a;
   logic [2:0] adr_b;
   logic [2:0] adr_w;
   logic       wr;
   logic       Z;
   logic       C;

   int n_chk;
   int n_err;

   ralu_multi_if #(.CW(3)) u_if ();

   ralu_multi #(
      .W (4),
      .N (8),
      .AW(3),
      .CW(3)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .DataIn(DataIn),
      .Rout  (Rout),
      .op    (op),
      .Pin   (Pin),
      .Pout  (Pout),
      .selA  (selA),
      .ldA   (ldA),
      .bmode (bmode),
      .acen  (acen),
      .ISL   (ISL),
      .ISR   (ISR),
      .OSL   (OSL),
      .OSR   (OSR),
      .adr_a (adr_a),
      .adr_b (adr_b),
      .adr_w (adr_w),
      .wr    (wr),
      .sh    (u_if.slave),
      .Z     (Z),
      .C     (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      DataIn      = '0;
      op          = 3'b101;
      Pin         = 1'b0;
      selA        = 1'b0;
      ldA         = 1'b0;
      bmode       = 2'b00;
      acen        = 1'b0;
      ISL         = 1'b0;
      ISR         = 1'b0;
      adr_a       = '0;
      adr_b       = '0;
      adr_w       = '0;
      wr          = 1'b0;
      u_if.start  = 1'b0;
      u_if.dir    = 1'b0;
      u_if.shcnt  = '0;
   endtask

   task automatic wr_rf(input logic [2:0] a,
                        input logic [3:0] v);
      DataIn = v;
      selA   = 1'b1;
      ldA    = 1'b1;
      tick();
      ldA    = 1'b0;
      op     = 3'b101;
      wr     = 1'b1;
      adr_w  = a;
      tick();
      wr     = 1'b0;
   endtask

   task automatic rd_rf(input  logic [2:0] a,
                        output logic [3:0] v);
      selA  = 1'b0;
      ldA   = 1'b1;
      adr_a = a;
      tick();
      ldA   = 1'b0;
      op    = 3'b101;
      acen  = 1'b1;
      tick();
      acen  = 1'b0;
      v     = Rout;
   endtask

   task automatic rd_b(output logic [3:0] v);
      op   = 3'b110;
      acen = 1'b1;
      tick();
      acen = 1'b0;
      v    = Rout;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (u_if.busy && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20)
         chk("busy_timeout", 32'(u_if.busy), 0);
   endtask

   logic [3:0] v;
   int         n;

   initial begin
      n_chk = 0;
      n_err = 0;
      clr();
      do_reset();
      chk("rst_rout", 32'(Rout), 0);
      chk("rst_z", 32'(Z), 0);
      chk("rst_c", 32'(C), 0);
      chk("rst_osl", 32'(OSL), 0);
      chk("rst_osr", 32'(OSR), 0);
      chk("rst_busy", 32'(u_if.busy), 0);

      for (int i = 0; i < 8; i++)
         wr_rf(3'(i), 4'h5);
      for (int i = 0; i < 8; i++) begin
         rd_rf(3'(i), v);
         chk($sformatf("rf5_%0d", i), 32'(v), 32'h5);
      end

      do_reset();
      chk("rst2_rout", 32'(Rout), 0);
      chk("rst2_z", 32'(Z), 0);
      chk("rst2_c", 32'(C), 0);
      for (int i = 0; i < 8; i++) begin
         rd_rf(3'(i), v);
         chk($sformatf("rf0_%0d", i), 32'(v), 0);
      end

      // F + 1 + 0 -> 0 with carry
      wr_rf(3'd1, 4'h1);
      DataIn = 4'hF;
      selA   = 1'b1;
      ldA    = 1'b1;
      bmode  = 2'b11;
      adr_b  = 3'd1;
      tick();
      ldA    = 1'b0;
      bmode  = 2'b00;
      op     = 3'b000;
      Pin    = 1'b0;
      #1;
      chk("add_pout", 32'(Pout), 1);
      acen   = 1'b1;
      tick();
      acen   = 1'b0;
      chk("add_rout", 32'(Rout), 0);
      chk("add_z", 32'(Z), 1);
      chk("add_c", 32'(C), 1);

      // 3 - 5 with Pin = 1 -> E, borrow
      wr_rf(3'd2, 4'h5);
      DataIn = 4'h3;
      selA   = 1'b1;
      ldA    = 1'b1;
      bmode  = 2'b11;
      adr_b  = 3'd2;
      tick();
      ldA    = 1'b0;
      bmode  = 2'b00;
      op     = 3'b001;
      Pin    = 1'b1;
      acen   = 1'b1;
      tick();
      acen   = 1'b0;
      Pin    = 1'b0;
      chk("sub_rout", 32'(Rout), 32'hE);
      chk("sub_c", 32'(C), 0);
      chk("sub_z", 32'(Z), 0);

      // write and read RF[2] in the same cycle
      DataIn = 4'h9;
      selA   = 1'b1;
      ldA    = 1'b1;
      tick();
      ldA    = 1'b0;
      op     = 3'b101;
      wr     = 1'b1;
      adr_w  = 3'd2;
      bmode  = 2'b11;
      adr_b  = 3'd2;
      tick();
      wr     = 1'b0;
      bmode  = 2'b00;
      rd_b(v);
      chk("rw_old", 32'(v), 32'h5);
      bmode  = 2'b11;
      tick();
      bmode  = 2'b00;
      rd_b(v);
      chk("rw_new", 32'(v), 32'h9);

      // left multi-shift of 1011 by 3
      wr_rf(3'd3, 4'b1011);
      bmode       = 2'b11;
      adr_b       = 3'd3;
      tick();
      bmode       = 2'b00;
      ISL         = 1'b0;
      u_if.start  = 1'b1;
      u_if.dir    = 1'b0;
      u_if.shcnt  = 3'd3;
      tick();
      u_if.start  = 1'b0;
      n = 0;
      while (u_if.busy && n < 20) begin
         bmode = 2'(n + 1);
         tick();
         n++;
      end
      bmode = 2'b00;
      chk("lsh_busy_cycles", 32'(n), 3);
      chk("lsh_osl", 32'(OSL), 1);
      rd_b(v);
      chk("lsh_b", 32'(v), 32'b1000);

      // zero count is a no-op
      u_if.start  = 1'b1;
      u_if.shcnt  = 3'd0;
      tick();
      u_if.start  = 1'b0;
      chk("zero_busy", 32'(u_if.busy), 0);
      rd_b(v);
      chk("zero_b", 32'(v), 32'b1000);

      // reset aborts a shift in progress
      bmode       = 2'b11;
      adr_b       = 3'd3;
      tick();
      bmode       = 2'b00;
      ISR         = 1'b1;
      u_if.start  = 1'b1;
      u_if.dir    = 1'b1;
      u_if.shcnt  = 3'd5;
      tick();
      u_if.start  = 1'b0;
      tick();
      tick();
      chk("abort_busy_pre", 32'(u_if.busy), 1);
      chk("abort_osr_pre", 32'(OSR), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 32'(u_if.busy), 0);
      chk("abort_osr", 32'(OSR), 0);
      rd_b(v);
      chk("abort_b", 32'(v), 0);

      // right shift 0110 by 2 with ISR = 1 -> 1101
      wr_rf(3'd0, 4'b0110);
      bmode       = 2'b11;
      adr_b       = 3'd0;
      tick();
      bmode       = 2'b00;
      ISR         = 1'b1;
      u_if.start  = 1'b1;
      u_if.dir    = 1'b1;
      u_if.shcnt  = 3'd2;
      tick();
      u_if.start  = 1'b0;
      chk("rsh_busy", 32'(u_if.busy), 1);
      wait_idle(n);
      chk("rsh_busy_cycles", 32'(n), 2);
      chk("rsh_osr", 32'(OSR), 1);
      rd_b(v);
      chk("rsh_b", 32'(v), 32'b1101);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
